// File: rtl/l2_line_responder.sv
// L2-side line responder: turns held-level 256-bit line requests into 4-beat 64-bit memory bursts.
// Optional per-beat memory timeout with error response is enabled by defining L2_MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module l2_line_responder #(
   parameter int unsigned BEATS          = 4,
   parameter int unsigned BEAT_W         = 64,
   parameter int unsigned LINE_W         = 256,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_read,
   input  logic              line_write,
   input  logic [31:0]       line_addr,
   input  logic [LINE_W-1:0] line_wdata,
   output logic              line_resp,
   output logic [LINE_W-1:0] line_rdata,
   output logic              line_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_addr,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic [BEAT_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if (LINE_W != BEATS * BEAT_W || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("l2_line_responder: inconsistent parameters");
   end

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] rdata_q;
   logic              accept, in_burst, beat, last_beat, abort;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^line_addr[4:0];
   assign accept    = (state == IDLE) && (line_read || line_write);
   assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
   assign beat      = in_burst && mem_resp;
   assign last_beat = beat && (cnt == LAST_BEAT);

`ifdef L2_MEM_TIMEOUT_EN
   localparam int unsigned WAIT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WAIT_W-1:0] wait_q;
   logic              err_q;

   // Abort fires on the edge where the silent-cycle count reaches TIMEOUT_CYCLES
   assign abort = in_burst && !mem_resp && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept || beat)
            wait_q <= '0;
         else if (in_burst)
            wait_q <= wait_q + WAIT_W'(1);
         if (accept)
            err_q <= 1'b0;
         else if (abort)
            err_q <= 1'b1;
      end
   end

   assign line_err = err_q;
`else
   assign abort    = 1'b0;
   assign line_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Read wins when both requests are raised together
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (line_read)
               state_nxt = RD_BURST;
            else if (line_write)
               state_nxt = WR_BURST;
         end
         RD_BURST, WR_BURST: begin
            if (last_beat || abort)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      line_resp = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = '0;
      case (state)
         RD_BURST: mem_read = 1'b1;
         WR_BURST: begin
            mem_write = 1'b1;
            mem_wdata = wdata_q[32'(cnt) * BEAT_W +: BEAT_W];
         end
         DONE:    line_resp = 1'b1;
         default: ;
      endcase
   end

   // Latched request copies, beat counter and assembled read line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            cnt    <= '0;
            addr_q <= {line_addr[31:5], 5'b0};
            if (!line_read)
               wdata_q <= line_wdata;
         end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
         end
         if ((state == RD_BURST) && mem_resp)
            rdata_q[32'(cnt) * BEAT_W +: BEAT_W] <= mem_rdata;
      end
   end

   assign mem_addr   = addr_q;
   assign line_rdata = rdata_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder with a negedge-driven memory model.
// Define L2_MEM_TIMEOUT_EN to also exercise the timeout abort path.
`timescale 1ns/1ps
module tb_l2_line_responder;

`ifdef L2_MEM_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         line_read, line_write;
   logic [31:0]  line_addr;
   logic [255:0] line_wdata;
   logic         line_resp;
   logic [255:0] line_rdata;
   logic         line_err;
   logic         mem_read, mem_write;
   logic [31:0]  mem_addr;
   logic [63:0]  mem_wdata;
   logic [63:0]  mem_rdata;
   logic         mem_resp;

   int checks = 0;
   int passed = 0;

   // memory model configuration (written by tests, read by the model)
   bit          model_en = 1'b0;
   bit          stray_resp = 1'b0;
   int          mem_wait = 0;
   int          hold_after = 4;
   logic [63:0] rd_beat [4];

   // memory model state and logs (written only by the model)
   int          wcnt = 0;
   int          beat_idx = 0;
   int          beat_total = 0;
   int          write_cycles = 0;
   logic [31:0] addr_log [64];
   logic [63:0] wdata_log [64];

   logic [255:0] line_exp [$];
   logic [63:0]  wr_exp [$];
   logic [255:0] cur_line = '0;

   l2_line_responder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .line_read(line_read), .line_write(line_write),
      .line_addr(line_addr), .line_wdata(line_wdata),
      .line_resp(line_resp), .line_rdata(line_rdata), .line_err(line_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   // Memory: after mem_wait silent cycles, acknowledge one beat; log what the DUT presents
   always @(negedge clk) begin
      mem_resp = 1'b0;
      if (!model_en) begin
         mem_resp = stray_resp;
      end else begin
         if (mem_write === 1'b1) write_cycles++;
         if (!rst_n || !(mem_read === 1'b1 || mem_write === 1'b1)) begin
            wcnt = 0;
            beat_idx = 0;
         end else if (beat_idx < hold_after) begin
            if (wcnt < mem_wait) begin
               wcnt++;
            end else begin
               wcnt = 0;
               mem_resp = 1'b1;
               addr_log[beat_total % 64] = mem_addr;
               wdata_log[beat_total % 64] = mem_wdata;
               if (mem_read === 1'b1) mem_rdata = rd_beat[beat_idx];
               beat_idx++;
               beat_total++;
            end
         end
      end
   end

   task automatic wait_resp(input int max_cyc, output int cyc, output bit ok);
      ok = 1'b0;
      cyc = 0;
      while (!ok && cyc < max_cyc) begin
         @(posedge clk); #1;
         cyc++;
         ok = (line_resp === 1'b1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; line_read = 1'b0; line_write = 1'b0;
      line_addr = '0; line_wdata = '0; mem_rdata = '0;
      model_en = 1'b0; stray_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({line_resp, line_err, mem_read, mem_write, mem_addr, mem_wdata, line_rdata} !== '0)
         $display("FAIL reset_outputs: got resp=%b err=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, want all 0",
                  line_resp, line_err, mem_read, mem_write, mem_addr, mem_wdata, line_rdata);
      else passed++;
      rst_n = 1'b1;
      stray_resp = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({line_resp, mem_read, mem_write} !== 3'b000)
            $display("FAIL idle_stray_resp: got resp/rd/wr=%b want 000", {line_resp, mem_read, mem_write});
         else passed++;
      end
      stray_resp = 1'b0;
      model_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      int cyc; bit ok; int b0; logic [255:0] exp;
      rd_beat[0] = {4{16'h1111}}; rd_beat[1] = {4{16'h2222}};
      rd_beat[2] = {4{16'h3333}}; rd_beat[3] = {4{16'h4444}};
      line_exp.push_back({rd_beat[3], rd_beat[2], rd_beat[1], rd_beat[0]});
      mem_wait = 2;
      b0 = beat_total;
      line_addr = 32'h0000_1234;
      line_read = 1'b1;
      wait_resp(100, cyc, ok);
      line_read = 1'b0;
      checks++;
      if (!ok) $display("FAIL read_resp: no line_resp within %0d cycles", cyc); else passed++;
      exp = (line_exp.size() > 0) ? line_exp.pop_front() : '0;
      checks++;
      if (line_rdata !== exp) $display("FAIL read_rdata: got %h want %h", line_rdata, exp); else passed++;
      checks++;
      if ({mem_read, mem_write, line_err} !== 3'b000)
         $display("FAIL read_done_outputs: got rd/wr/err=%b want 000", {mem_read, mem_write, line_err});
      else passed++;
      checks++;
      if (beat_total - b0 != 4) $display("FAIL read_beats: got %0d want 4", beat_total - b0); else passed++;
      for (int i = b0; i < beat_total; i++) begin
         checks++;
         if (addr_log[i % 64] !== 32'h0000_1220)
            $display("FAIL read_mem_addr: got %h want 00001220", addr_log[i % 64]);
         else passed++;
      end
      @(posedge clk); #1;
      checks++;
      if (line_resp !== 1'b0) $display("FAIL read_resp_pulse: got %b want 0", line_resp); else passed++;
      cur_line = exp;
   endtask

   task automatic test_write();
      int cyc; bit ok; int b0; logic [63:0] w;
      logic [63:0] d [4];
      d[0] = {4{16'hAAAA}}; d[1] = {4{16'hBBBB}}; d[2] = {4{16'hCCCC}}; d[3] = {4{16'hDDDD}};
      for (int i = 0; i < 4; i++) wr_exp.push_back(d[i]);
      mem_wait = 0;
      b0 = beat_total;
      line_addr = 32'h8000_0040;
      line_wdata = {d[3], d[2], d[1], d[0]};
      line_write = 1'b1;
      @(posedge clk); #1;
      line_wdata = '1;
      line_addr = 32'hFFFF_FFFF;
      wait_resp(100, cyc, ok);
      cyc++;
      line_write = 1'b0;
      checks++;
      if (!ok || cyc != 5) $display("FAIL write_latency: got ok=%b edges=%0d want ok=1 edges=5", ok, cyc); else passed++;
      checks++;
      if (beat_total - b0 != 4) $display("FAIL write_beats: got %0d want 4", beat_total - b0); else passed++;
      for (int i = b0; i < beat_total; i++) begin
         w = (wr_exp.size() > 0) ? wr_exp.pop_front() : 64'hx;
         checks++;
         if (wdata_log[i % 64] !== w || addr_log[i % 64] !== 32'h8000_0040)
            $display("FAIL write_beat: got data=%h addr=%h want data=%h addr=80000040",
                     wdata_log[i % 64], addr_log[i % 64], w);
         else passed++;
      end
      checks++;
      if (line_rdata !== cur_line) $display("FAIL write_keeps_rdata: got %h want %h", line_rdata, cur_line); else passed++;
      @(posedge clk); #1;
      checks++;
      if ({line_resp, mem_write} !== 2'b00) $display("FAIL write_end: got resp/wr=%b want 00", {line_resp, mem_write}); else passed++;
   endtask

   task automatic test_both();
      int cyc; bit ok; int wc0; logic [255:0] exp;
      rd_beat[0] = 64'h0123_4567_89AB_CDEF; rd_beat[1] = 64'hFEDC_BA98_7654_3210;
      rd_beat[2] = 64'h5555_0000_AAAA_FFFF; rd_beat[3] = 64'h0F0F_F0F0_1234_8765;
      line_exp.push_back({rd_beat[3], rd_beat[2], rd_beat[1], rd_beat[0]});
      mem_wait = 1;
      wc0 = write_cycles;
      line_addr = 32'h0000_0400;
      line_wdata = {8{32'hDEAD_BEEF}};
      line_read = 1'b1;
      line_write = 1'b1;
      wait_resp(100, cyc, ok);
      line_read = 1'b0;
      line_write = 1'b0;
      exp = (line_exp.size() > 0) ? line_exp.pop_front() : '0;
      checks++;
      if (!ok || line_rdata !== exp) $display("FAIL both_read: got ok=%b rdata=%h want ok=1 rdata=%h", ok, line_rdata, exp); else passed++;
      checks++;
      if (write_cycles != wc0) $display("FAIL both_no_write: got %0d write cycles want 0", write_cycles - wc0); else passed++;
      cur_line = exp;
      @(posedge clk); #1;
   endtask

`ifdef L2_MEM_TIMEOUT_EN
   task automatic test_timeout();
      int cyc; bit ok; logic [255:0] exp;
      rd_beat[0] = {4{16'h7A7A}}; rd_beat[1] = '1; rd_beat[2] = '1; rd_beat[3] = '1;
      exp = {cur_line[255:64], rd_beat[0]};
      mem_wait = 0;
      hold_after = 1;
      line_addr = 32'h0000_2000;
      line_read = 1'b1;
      wait_resp(60, cyc, ok);
      line_read = 1'b0;
      checks++;
      if (!ok || cyc != 10) $display("FAIL timeout_latency: got ok=%b edges=%0d want ok=1 edges=10", ok, cyc); else passed++;
      checks++;
      if (line_err !== 1'b1 || mem_read !== 1'b0) $display("FAIL timeout_err: got err=%b rd=%b want err=1 rd=0", line_err, mem_read); else passed++;
      checks++;
      if (line_rdata !== exp) $display("FAIL timeout_partial: got %h want %h", line_rdata, exp); else passed++;
      cur_line = exp;
      hold_after = 4;
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_back_to_back();
      int cyc; bit ok; int b1; logic [255:0] exp; logic [63:0] w;
      rd_beat[0] = 64'hA0A0_0000_0000_0001; rd_beat[1] = 64'hA0A0_0000_0000_0002;
      rd_beat[2] = 64'hA0A0_0000_0000_0003; rd_beat[3] = 64'hA0A0_0000_0000_0004;
      line_exp.push_back({rd_beat[3], rd_beat[2], rd_beat[1], rd_beat[0]});
      mem_wait = 1;
      line_addr = 32'h0000_3000;
      line_read = 1'b1;
      wait_resp(100, cyc, ok);
      // reissue a write while line_resp is high so IDLE samples it right away
      line_read = 1'b0;
      for (int i = 0; i < 4; i++) wr_exp.push_back(64'hB0B0_0000_0000_0010 + 64'(i));
      line_addr = 32'h0000_3040;
      line_wdata = {64'hB0B0_0000_0000_0013, 64'hB0B0_0000_0000_0012,
                    64'hB0B0_0000_0000_0011, 64'hB0B0_0000_0000_0010};
      line_write = 1'b1;
      exp = (line_exp.size() > 0) ? line_exp.pop_front() : '0;
      checks++;
      if (!ok || line_rdata !== exp || line_err !== 1'b0)
         $display("FAIL b2b_read: got ok=%b err=%b rdata=%h want ok=1 err=0 rdata=%h", ok, line_err, line_rdata, exp);
      else passed++;
      cur_line = exp;
      mem_wait = 0;
      b1 = beat_total;
      wait_resp(100, cyc, ok);
      line_write = 1'b0;
      checks++;
      if (!ok || cyc != 6) $display("FAIL b2b_write_latency: got ok=%b edges=%0d want ok=1 edges=6", ok, cyc); else passed++;
      checks++;
      if (beat_total - b1 != 4) $display("FAIL b2b_write_beats: got %0d want 4", beat_total - b1); else passed++;
      for (int i = b1; i < beat_total; i++) begin
         w = (wr_exp.size() > 0) ? wr_exp.pop_front() : 64'hx;
         checks++;
         if (wdata_log[i % 64] !== w || addr_log[i % 64] !== 32'h0000_3040)
            $display("FAIL b2b_write_beat: got data=%h addr=%h want data=%h addr=00003040",
                     wdata_log[i % 64], addr_log[i % 64], w);
         else passed++;
      end
      checks++;
      if (line_rdata !== cur_line) $display("FAIL b2b_rdata_kept: got %h want %h", line_rdata, cur_line); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int cyc; bit ok; int b0; bit seen; logic [255:0] exp;
      rd_beat[0] = {4{16'hC001}}; rd_beat[1] = {4{16'hC002}};
      rd_beat[2] = {4{16'hC003}}; rd_beat[3] = {4{16'hC004}};
      mem_wait = 1;
      b0 = beat_total;
      line_addr = 32'h0000_5000;
      line_read = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk); #1;
         seen = (beat_total - b0 >= 2);
      end
      checks++;
      if (!seen) $display("FAIL midreset_two_beats: got %0d beats want 2", beat_total - b0); else passed++;
      #2;
      rst_n = 1'b0;
      line_read = 1'b0;
      #1;
      checks++;
      if ({line_resp, line_err, mem_read, mem_write, mem_addr, mem_wdata, line_rdata} !== '0)
         $display("FAIL midreset_async: got resp=%b rd=%b addr=%h rdata=%h want all 0",
                  line_resp, mem_read, mem_addr, line_rdata);
      else passed++;
      seen = 1'b0;
      repeat (2) begin @(posedge clk); #1; seen |= (line_resp !== 1'b0); end
      rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; seen |= (line_resp !== 1'b0) || (mem_read !== 1'b0); end
      checks++;
      if (seen) $display("FAIL midreset_no_resp: got a line_resp or mem_read after abort want none"); else passed++;
      rd_beat[0] = {4{16'hD001}}; rd_beat[1] = {4{16'hD002}};
      rd_beat[2] = {4{16'hD003}}; rd_beat[3] = {4{16'hD004}};
      line_exp.push_back({rd_beat[3], rd_beat[2], rd_beat[1], rd_beat[0]});
      line_addr = 32'h0000_6010;
      line_read = 1'b1;
      wait_resp(100, cyc, ok);
      line_read = 1'b0;
      exp = (line_exp.size() > 0) ? line_exp.pop_front() : '0;
      checks++;
      if (!ok || line_rdata !== exp) $display("FAIL midreset_next_read: got ok=%b rdata=%h want ok=1 rdata=%h", ok, line_rdata, exp); else passed++;
      checks++;
      if (mem_addr !== 32'h0000_6000) $display("FAIL midreset_next_addr: got %h want 00006000", mem_addr); else passed++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_both();
`ifdef L2_MEM_TIMEOUT_EN
      test_timeout();
`endif
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

endmodule
